// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: divider FSM encoding,
// forwarding-select codes and the default divider latency.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// Divider sequencer: launches the iterative divider, counts its RUN cycles
// and produces a one-cycle commit; a pending flush aborts it back to IDLE.
module pipe_ctrl_div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic ex_div,
    input  logic flush,
    output logic div_start,
    output logic div_busy,
    output logic div_commit,
    output logic div_stall
);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        div_start  = 1'b0;
        div_busy   = 1'b0;
        div_commit = 1'b0;
        div_stall  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ex_div && !flush) begin
                    div_start = 1'b1;
                    div_stall = 1'b1;
                    state_nxt = ST_RUN;
                    cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            ST_RUN: begin
                div_busy  = 1'b1;
                div_stall = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // ex_div is still high here (same instruction); returning to
                // IDLE without looking at it prevents a spurious relaunch.
                div_commit = !flush;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (flush) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end

        if (!resetn) begin
            div_start  = 1'b0;
            div_busy   = 1'b0;
            div_commit = 1'b0;
            div_stall  = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/forwarding scheduler for the 5-stage pipeline: load-use
// detection, EX operand forwarding and divider hold, with exception flush.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       ex_load,
    input  logic       ex_regwen,
    input  logic [4:0] ex_wreg,
    input  logic       ex_div,
    input  logic       mem_regwen,
    input  logic [4:0] mem_wreg,
    input  logic       wb_regwen,
    input  logic [4:0] wb_wreg,
    input  logic       mem_exc,
    input  logic       mem_eret,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       stall_id_ex,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       flush_ex_mem,
    output logic       flush_mem_wb,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       div_start,
    output logic       div_busy,
    output logic       div_commit
);

    logic flush;
    logic load_use;
    logic div_stall;

    // MEM holds the younger result, so it wins over WB; $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       m_wen,
        input logic [4:0] m_reg,
        input logic       w_wen,
        input logic [4:0] w_reg
    );
        if (m_wen && (m_reg != 5'd0) && (m_reg == src)) begin
            return FWD_MEM;
        end else if (w_wen && (w_reg != 5'd0) && (w_reg == src)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    assign flush = mem_exc | mem_eret;

    assign load_use = ex_load && ex_regwen && (ex_wreg != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_wreg)) ||
                       (id_use_rt && (id_rt == ex_wreg)));

    pipe_ctrl_div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_seq (
        .clk        (clk),
        .resetn     (resetn),
        .ex_div     (ex_div),
        .flush      (flush),
        .div_start  (div_start),
        .div_busy   (div_busy),
        .div_commit (div_commit),
        .div_stall  (div_stall)
    );

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        fwd_a_sel    = FWD_REG;
        fwd_b_sel    = FWD_REG;

        if (resetn) begin
            fwd_a_sel = fwd_sel(ex_rs, mem_regwen, mem_wreg, wb_regwen, wb_wreg);
            fwd_b_sel = fwd_sel(ex_rt, mem_regwen, mem_wreg, wb_regwen, wb_wreg);

            if (flush) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (div_stall) begin
                // Holding ID/EX also covers any load-use seen while dividing.
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all
// checked against a cycle-age reference model of the scheduler.
module tb_pipe_ctrl;

    localparam int DC = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic       id_use_rs, id_use_rt, ex_load, ex_regwen, ex_div;
    logic       mem_regwen, wb_regwen, mem_exc, mem_eret;
    logic       stall_pc, stall_if_id, stall_id_ex;
    logic       flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       div_start, div_busy, div_commit;

    int checks = 0;
    int errors = 0;

    // Model: cycles since the divider was launched (0 = no division).
    int   age = 0;
    logic e_stall_pc, e_stall_if_id, e_stall_id_ex;
    logic e_flush_if_id, e_flush_id_ex, e_flush_ex_mem, e_flush_mem_wb;
    logic [1:0] e_fwd_a, e_fwd_b;
    logic e_start, e_busy, e_commit;

    pipe_ctrl #(.DIV_CYCLES(DC), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_load(ex_load), .ex_regwen(ex_regwen),
        .ex_wreg(ex_wreg), .ex_div(ex_div),
        .mem_regwen(mem_regwen), .mem_wreg(mem_wreg),
        .wb_regwen(wb_regwen), .wb_wreg(wb_wreg),
        .mem_exc(mem_exc), .mem_eret(mem_eret),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .div_start(div_start), .div_busy(div_busy), .div_commit(div_commit)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] src_of(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        if (mem_regwen && mem_wreg == r) return 2'b01;
        if (wb_regwen && wb_wreg == r) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_eval();
        logic fl, lu, dst;
        fl = mem_exc || mem_eret;
        lu = ex_load && ex_regwen && ex_wreg != 5'd0 &&
             ((id_use_rs && id_rs == ex_wreg) || (id_use_rt && id_rt == ex_wreg));
        e_busy   = resetn && age >= 1 && age <= DC;
        e_start  = resetn && age == 0 && ex_div && !fl;
        e_commit = resetn && age == DC + 1 && !fl;
        dst      = e_start || e_busy;
        e_stall_pc     = resetn && !fl && (dst || lu);
        e_stall_if_id  = e_stall_pc;
        e_stall_id_ex  = resetn && !fl && dst;
        e_flush_if_id  = resetn && fl;
        e_flush_id_ex  = resetn && (fl || (lu && !dst));
        e_flush_ex_mem = resetn && (fl || dst);
        e_flush_mem_wb = resetn && fl;
        e_fwd_a = resetn ? src_of(ex_rs) : 2'b00;
        e_fwd_b = resetn ? src_of(ex_rt) : 2'b00;
    endtask

    // Called mid-cycle with inputs stable: compare every output to the model.
    task automatic eval_cycle();
        #3;
        model_eval();
        chk1("stall_pc", stall_pc, e_stall_pc);
        chk1("stall_if_id", stall_if_id, e_stall_if_id);
        chk1("stall_id_ex", stall_id_ex, e_stall_id_ex);
        chk1("flush_if_id", flush_if_id, e_flush_if_id);
        chk1("flush_id_ex", flush_id_ex, e_flush_id_ex);
        chk1("flush_ex_mem", flush_ex_mem, e_flush_ex_mem);
        chk1("flush_mem_wb", flush_mem_wb, e_flush_mem_wb);
        chk2("fwd_a_sel", fwd_a_sel, e_fwd_a);
        chk2("fwd_b_sel", fwd_b_sel, e_fwd_b);
        chk1("div_start", div_start, e_start);
        chk1("div_busy", div_busy, e_busy);
        chk1("div_commit", div_commit, e_commit);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        if (!resetn || mem_exc || mem_eret) age = 0;
        else if (e_start) age = 1;
        else if (age == DC + 1) age = 0;
        else if (age > 0) age = age + 1;
        #1;
    endtask

    task automatic quiet();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_load = 0; ex_regwen = 0; ex_wreg = 0; ex_div = 0;
        mem_regwen = 0; mem_wreg = 0; wb_regwen = 0; wb_wreg = 0;
        mem_exc = 0; mem_eret = 0;
    endtask

    initial begin
        quiet();
        resetn = 1'b0;
        // Reset with hazards and a div present: everything must stay low.
        ex_div = 1; ex_load = 1; ex_regwen = 1; ex_wreg = 3; id_rs = 3; id_use_rs = 1;
        mem_regwen = 1; mem_wreg = 7; ex_rs = 7;
        eval_cycle();
        chk1("rst_stall_pc", stall_pc, 1'b0);
        chk1("rst_div_start", div_start, 1'b0);
        chk2("rst_fwd_a", fwd_a_sel, 2'b00);
        next_cycle();
        quiet(); resetn = 1'b1;
        eval_cycle(); next_cycle();

        // Load-use on rs, then the bubble cycle.
        ex_load = 1; ex_regwen = 1; ex_wreg = 3; id_rs = 3; id_use_rs = 1;
        eval_cycle();
        chk1("lu_stall_pc", stall_pc, 1'b1);
        chk1("lu_flush_id_ex", flush_id_ex, 1'b1);
        chk1("lu_stall_id_ex", stall_id_ex, 1'b0);
        next_cycle();
        quiet();
        eval_cycle();
        chk1("lu_after_stall_pc", stall_pc, 1'b0);
        next_cycle();
        ex_load = 1; ex_regwen = 1; ex_wreg = 0; id_rs = 0; id_use_rs = 1;
        eval_cycle();
        chk1("lu_r0_stall_pc", stall_pc, 1'b0);
        next_cycle();

        // Forwarding priority and $0.
        quiet();
        ex_rs = 5; mem_wreg = 5; wb_wreg = 5; mem_regwen = 1; wb_regwen = 1;
        eval_cycle();
        chk2("fwd_mem_prio", fwd_a_sel, 2'b01);
        next_cycle();
        mem_regwen = 0;
        eval_cycle();
        chk2("fwd_wb", fwd_a_sel, 2'b10);
        next_cycle();
        ex_rt = 0; wb_wreg = 0;
        eval_cycle();
        chk2("fwd_r0", fwd_b_sel, 2'b00);
        next_cycle();

        // Full division with ex_div held until commit.
        quiet();
        for (int c = 0; c <= DC + 2; c++) begin
            ex_div = (c <= DC + 1);
            eval_cycle();
            chk1("div_seq_start", div_start, c == 0);
            chk1("div_seq_busy", div_busy, c >= 1 && c <= DC);
            chk1("div_seq_commit", div_commit, c == DC + 1);
            chk1("div_seq_stall", stall_pc, c <= DC);
            next_cycle();
        end

        // Exception at cycle 10 aborts the division.
        quiet();
        for (int c = 0; c <= DC + 4; c++) begin
            ex_div  = (c <= 10);
            mem_exc = (c == 10);
            eval_cycle();
            if (c == 10) begin
                chk1("abort_flush_if_id", flush_if_id, 1'b1);
                chk1("abort_flush_mem_wb", flush_mem_wb, 1'b1);
                chk1("abort_stall_id_ex", stall_id_ex, 1'b0);
            end
            if (c == 11) chk1("abort_busy_after", div_busy, 1'b0);
            chk1("abort_no_commit", div_commit, 1'b0);
            next_cycle();
        end

        // Reset for one cycle at cycle 5, then a fresh division.
        quiet();
        for (int c = 0; c <= 5; c++) begin
            ex_div = 1;
            resetn = (c != 5);
            eval_cycle();
            if (c == 5) begin
                chk1("rmid_busy", div_busy, 1'b0);
                chk1("rmid_flush_ex_mem", flush_ex_mem, 1'b0);
            end
            next_cycle();
        end
        resetn = 1'b1;
        eval_cycle();
        chk1("rmid_restart", div_start, 1'b1);
        next_cycle();
        for (int c = 1; c <= DC + 1; c++) begin
            eval_cycle(); next_cycle();
        end
        ex_div = 0;
        eval_cycle(); next_cycle();

        // eret together with a new div in IDLE.
        quiet();
        mem_eret = 1; ex_div = 1;
        eval_cycle();
        chk1("eret_no_start", div_start, 1'b0);
        chk1("eret_flush_ex_mem", flush_ex_mem, 1'b1);
        next_cycle();
        quiet();
        eval_cycle();
        chk1("eret_idle_busy", div_busy, 1'b0);
        next_cycle();

        // Random traffic with small register numbers to provoke matches.
        for (int n = 0; n < 2000; n++) begin
            resetn     = ($urandom_range(0, 99) != 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_use_rs  = 1'($urandom_range(0, 1));
            id_use_rt  = 1'($urandom_range(0, 1));
            ex_rs      = 5'($urandom_range(0, 3));
            ex_rt      = 5'($urandom_range(0, 3));
            ex_load    = 1'($urandom_range(0, 1));
            ex_regwen  = 1'($urandom_range(0, 1));
            ex_wreg    = 5'($urandom_range(0, 3));
            ex_div     = ($urandom_range(0, 5) == 0);
            mem_regwen = 1'($urandom_range(0, 1));
            mem_wreg   = 5'($urandom_range(0, 3));
            wb_regwen  = 1'($urandom_range(0, 1));
            wb_wreg    = 5'($urandom_range(0, 3));
            mem_exc    = ($urandom_range(0, 59) == 0);
            mem_eret   = ($urandom_range(0, 59) == 0);
            eval_cycle();
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
